grid_loader: RTL and testbench
==============================

Name: grid_loader

Overview:
- Upstream loader stage for the day-4 grid memory `mem`.
- Accepts a byte stream of puzzle text, packs `'@'` cells into TX_DATA_WIDTH-bit partial row vectors, and writes each vector into the bank at its row/column address using the `mem` write handshake.
- When the stream ends it asserts `done_out`. That signal hands bank ownership to the freemachine stage.

Parameters:
- TX_DATA_WIDTH, default `` `TX_DATA_WIDTH ``: bits per partial vector and per bank write.
- COL_ADDR_WIDTH, default `` `COL_ADDR_WIDTH ``: width of the column address.
- BANK_ADDR_WIDTH, default `` `BANK_ADDR_WIDTH ``: width of the row address.
- MAX_COLS, default `` `MAX_COLS ``: maximum grid columns per row.
- BANK_DEPTH, default `` `BANK_DEPTH ``: number of rows the bank holds.

Ports:
- clock  in  1  single clock, posedge.
- reset  in  1  synchronous, active-high reset.
- start_in  in  1  one-cycle pulse. Arms the loader and clears counters, error and done.
- char_valid_in  in  1  `char_in` is valid.
- char_in  in  8  ASCII character.
- char_last_in  in  1  marks the final character of the stream; qualified by `char_valid_in`.
- char_ready_out  out  1  loader accepts a character this cycle.
- ack_in  in  1  `mem` ack.
- busy_in  in  1  `mem` busy.
- write_en_out  out  1  bank write request.
- row_addr_out  out  BANK_ADDR_WIDTH  bank row of the current write.
- col_addr_out  out  COL_ADDR_WIDTH  start column of the current chunk.
- partial_vec_out  out  TX_DATA_WIDTH  chunk data; bit i corresponds to column col_addr_out+i.
- rows_out  out  BANK_ADDR_WIDTH+1  count of completed non-empty rows.
- overflow_err_out  out  1  sticky flag: a row or column overflow occurred.
- done_out  out  1  load complete, held high.

Behaviour:
- **Reset:** every output is 0. The FSM enters IDLE and the column counter, row counter and packing register clear. Reset in any state, including mid-WRITE, drops `write_en_out` at the next edge.
- **FSM states:** IDLE, FILL, WRITE, RELEASE, DONE.
- **IDLE:**
  - `char_ready_out` = 0.
  - `start_in` → FILL, with counters, error flag and `done_out` cleared.
- **FILL:**
  - `char_ready_out` = 1. A character is accepted when `char_valid_in` && `char_ready_out`.
  - `'@'` sets bit `col % W` of the packing register. Any other printable character leaves that bit 0. CR (13) is ignored and does not advance the column.
  - After storing, the column increments.
  - If the stored bit completes a chunk (`col % W == W-1`), latch the register into `partial_vec_out`, set `col_addr_out = col - (W-1)` and `row_addr_out = row`, clear the register, and go to WRITE.
- **Newline (10):**
  - Bits pending (`col % W != 0`): flush at `col_addr_out = col - col%W` through WRITE. Afterwards the row increments, column resets to 0, and `rows_out` increments.
  - No bits pending and `col > 0`: the row increments in the same cycle and the state stays FILL.
  - `col == 0` (empty line): ignored; no row increment.
- **Column overflow:** a character arriving when `col == MAX_COLS` is dropped (still accepted) and sets `overflow_err_out`. Dropping continues until the next newline.
- **Row overflow:** if `row == BANK_DEPTH`, no write is issued and `overflow_err_out` sets. Chunk bookkeeping still proceeds.
- **WRITE:**
  - `write_en_out` = 1. Address and data are held stable.
  - On `ack_in == 1`: `write_en_out` drops at that edge; go to RELEASE.
- **RELEASE:**
  - `write_en_out` = 0.
  - If `busy_in` || `ack_in`, wait here.
  - Once both are low, return to FILL, or to DONE if a last-flush is complete.
- **End of stream:** on the `char_last_in` beat, process the character normally.
  - If bits remain pending, flush them at the current row and count the row as for a newline.
  - Then go to DONE.
  - If the last character is a newline, the newline rules apply and the FSM then goes to DONE.
- **DONE:**
  - `done_out` = 1 and `char_ready_out` = 0.
  - `start_in` re-arms: go to FILL, clear `done_out`.
- **Latency:** a completed chunk reaches `write_en_out` exactly 1 cycle after its accepting edge. Minimum throughput is one chunk per 3 cycles when ack arrives immediately.
- **Simultaneous events:** `start_in` outside IDLE/DONE is ignored. `char_last_in` without `char_valid_in` is ignored.

Test Plan:
Bench overrides TX_DATA_WIDTH=4, MAX_COLS=10, BANK_DEPTH=4.
1. Reset held 3 cycles, then released → all outputs 0 and FSM in IDLE. Characters presented before `start_in` are not accepted (`char_ready_out` = 0).
2. `start_in`, then stream `"@.@@."` + `"\n"` with `mem` acking in 2 cycles:
   - First write: row 0, col 0, vec 4'b1101.
   - Second write: row 0, col 4, vec 4'b0000.
   - `rows_out` = 1.
   - Each `write_en_out` stays high until ack; no new request until ack is low.
3. Stream `"@@@@\n\n@"` with last on the final `'@'`:
   - One write: row 0, col 0, vec 4'b1111.
   - Newline after a flushed chunk issues no write; the empty line is skipped.
   - Final write: row 1, col 0, vec 4'b0001.
   - `rows_out` = 2 and `done_out` = 1.
4. A row of 12 `'@'` followed by a newline → writes at col 0, col 4 and col 8 (vec 4'b0011). `overflow_err_out` = 1; `rows_out` = 1.
5. Stream 5 rows of `"@\n"` → rows 0–3 written; the fifth row issues no write and sets `overflow_err_out`.
6. Assert `reset` while in WRITE with ack withheld → `write_en_out` = 0 the next cycle and the FSM is in IDLE. A subsequent `start_in` plus stream loads correctly from row 0.

Source files
------------

// File: rtl/grid_loader.sv
// Loader for the day-4 grid bank: packs '@' cells of a text stream into
// TX_DATA_WIDTH-bit row chunks and writes each chunk through the mem handshake.
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 8
`endif
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef MAX_COLS
`define MAX_COLS 140
`endif
`ifndef BANK_DEPTH
`define BANK_DEPTH 140
`endif

module grid_loader #(
  parameter int TX_DATA_WIDTH   = `TX_DATA_WIDTH,
  parameter int COL_ADDR_WIDTH  = `COL_ADDR_WIDTH,
  parameter int BANK_ADDR_WIDTH = `BANK_ADDR_WIDTH,
  parameter int MAX_COLS        = `MAX_COLS,
  parameter int BANK_DEPTH      = `BANK_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_in,
  input  logic                       char_valid_in,
  input  logic [7:0]                 char_in,
  input  logic                       char_last_in,
  output logic                       char_ready_out,
  input  logic                       ack_in,
  input  logic                       busy_in,
  output logic                       write_en_out,
  output logic [BANK_ADDR_WIDTH-1:0] row_addr_out,
  output logic [COL_ADDR_WIDTH-1:0]  col_addr_out,
  output logic [TX_DATA_WIDTH-1:0]   partial_vec_out,
  output logic [BANK_ADDR_WIDTH:0]   rows_out,
  output logic                       overflow_err_out,
  output logic                       done_out
);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, RELEASE, DONE} state_e;

  localparam int RW = BANK_ADDR_WIDTH + 1;
  localparam logic [7:0] CHAR_AT = 8'h40;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [COL_ADDR_WIDTH-1:0] W_C   = COL_ADDR_WIDTH'(TX_DATA_WIDTH);
  localparam logic [COL_ADDR_WIDTH-1:0] MAX_C = COL_ADDR_WIDTH'(MAX_COLS);
  localparam logic [RW-1:0]             DEPTH = RW'(BANK_DEPTH);

  state_e                     state_q, state_d;
  logic [COL_ADDR_WIDTH-1:0]  col_q, col_d;
  logic [RW-1:0]              row_q, row_d;
  logic [TX_DATA_WIDTH-1:0]   pack_q, pack_d;
  logic [TX_DATA_WIDTH-1:0]   vec_q, vec_d;
  logic [COL_ADDR_WIDTH-1:0]  col_addr_q, col_addr_d;
  logic [BANK_ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
  logic                       err_q, err_d;
  logic                       last_q, last_d;

  logic                       is_lf, is_cr, store, chunk_full, end_row, emit;
  logic [COL_ADDR_WIDTH-1:0]  col_mod, col_next, col_next_mod;
  logic [TX_DATA_WIDTH-1:0]   pack_set;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      pack_q     <= '0;
      vec_q      <= '0;
      col_addr_q <= '0;
      row_addr_q <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pack_q     <= pack_d;
      vec_q      <= vec_d;
      col_addr_q <= col_addr_d;
      row_addr_q <= row_addr_d;
      err_q      <= err_d;
      last_q     <= last_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    pack_d     = pack_q;
    vec_d      = vec_q;
    col_addr_d = col_addr_q;
    row_addr_d = row_addr_q;
    err_d      = err_q;
    last_d     = last_q;

    // Character decode: a chunk completes on its last column; a newline or the
    // final beat closes the row and flushes whatever columns are pending.
    is_lf        = (char_in == CHAR_LF);
    is_cr        = (char_in == CHAR_CR);
    col_mod      = col_q % W_C;
    store        = !is_lf && !is_cr && (col_q != MAX_C);
    col_next     = store ? col_q + COL_ADDR_WIDTH'(1) : col_q;
    col_next_mod = col_next % W_C;
    chunk_full   = store && (col_mod == W_C - COL_ADDR_WIDTH'(1));
    end_row      = is_lf || char_last_in;
    emit         = chunk_full || (end_row && (col_next_mod != '0));
    pack_set     = (store && char_in == CHAR_AT)
                 ? (pack_q | (TX_DATA_WIDTH'(1) << col_mod)) : pack_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d = FILL;
          col_d   = '0;
          row_d   = '0;
          pack_d  = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      FILL: begin
        if (char_valid_in) begin
          pack_d = pack_set;
          col_d  = col_next;
          if (!is_lf && !is_cr && col_q == MAX_C) err_d = 1'b1;
          if (end_row && col_next != '0) begin
            col_d = '0;
            if (row_q != DEPTH) row_d = row_q + RW'(1);
          end
          if (emit) begin
            pack_d = '0;
            if (row_q != DEPTH) begin
              vec_d      = pack_set;
              col_addr_d = col_next - (chunk_full ? W_C : col_next_mod);
              row_addr_d = row_q[BANK_ADDR_WIDTH-1:0];
              last_d     = char_last_in;
              state_d    = WRITE;
            end else begin
              err_d = 1'b1;
              if (char_last_in) state_d = DONE;
            end
          end else if (char_last_in) begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (ack_in) state_d = RELEASE;
      end
      RELEASE: begin
        if (!busy_in && !ack_in) state_d = last_q ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  assign char_ready_out   = (state_q == FILL);
  assign write_en_out     = (state_q == WRITE);
  assign done_out         = (state_q == DONE);
  assign row_addr_out     = row_addr_q;
  assign col_addr_out     = col_addr_q;
  assign partial_vec_out  = vec_q;
  assign rows_out         = row_q;
  assign overflow_err_out = err_q;

endmodule

// File: tb/tb_grid_loader.sv
// Self-checking bench for grid_loader: directed vector table, mid-write reset,
// and random grids compared against a line-oriented reference model.
module tb_grid_loader;

  localparam int W     = 4;
  localparam int MAXC  = 10;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset, start_in, char_valid_in, char_last_in;
  logic [7:0] char_in;
  logic       char_ready_out, ack_in, busy_in, write_en_out;
  logic [2:0] row_addr_out;
  logic [3:0] col_addr_out, partial_vec_out, rows_out;
  logic       overflow_err_out, done_out;

  int tests = 0;
  int fails = 0;
  int ack_delay = 1;
  int busy_hold = 0;
  bit hold_ack  = 1'b0;
  int got[$];

  typedef struct {
    string       txt;
    int          ack_d;
    int          busy_h;
    int          n_w;
    logic [71:0] ws;     // up to six writes, 3 hex digits each: row, col, vec
    int          rows;   // -1: not compared
    logic        err;
  } vec_t;

  grid_loader #(
    .TX_DATA_WIDTH(W), .COL_ADDR_WIDTH(4), .BANK_ADDR_WIDTH(3),
    .MAX_COLS(MAXC), .BANK_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start_in(start_in),
    .char_valid_in(char_valid_in), .char_in(char_in), .char_last_in(char_last_in),
    .char_ready_out(char_ready_out), .ack_in(ack_in), .busy_in(busy_in),
    .write_en_out(write_en_out), .row_addr_out(row_addr_out),
    .col_addr_out(col_addr_out), .partial_vec_out(partial_vec_out),
    .rows_out(rows_out), .overflow_err_out(overflow_err_out), .done_out(done_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int cur_write();
    return (int'(row_addr_out) << 8) | (int'(col_addr_out) << 4) | int'(partial_vec_out);
  endfunction

  // Memory responder: acks after ack_delay cycles, optionally stays busy, and
  // polices that a request is held stable until ack and not reissued early.
  initial begin
    int cnt = 0;
    int bcnt = 0;
    bit req_open = 1'b0;
    int cur = 0;
    ack_in = 1'b0;
    busy_in = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ack_in = 1'b0; busy_in = 1'b0; cnt = 0; req_open = 1'b0;
        continue;
      end
      if (ack_in) begin
        check("we_drop_after_ack", write_en_out, 0);
        ack_in = 1'b0;
        req_open = 1'b0;
        bcnt = busy_hold;
        busy_in = (busy_hold > 0);
      end else if (busy_in) begin
        check("no_req_while_busy", write_en_out, 0);
        bcnt--;
        if (bcnt <= 0) busy_in = 1'b0;
      end else if (write_en_out) begin
        if (!req_open) begin
          cur = cur_write();
          got.push_back(cur);
          req_open = 1'b1;
          cnt = 0;
        end else if (cur_write() != cur) begin
          check("write_hold_stable", cur_write(), cur);
        end
        cnt++;
        if (!hold_ack && cnt >= ack_delay) ack_in = 1'b1;
      end else if (req_open) begin
        check("we_early_drop", write_en_out, 1);
        req_open = 1'b0;
      end
    end
  end

  // Reference: split into lines, drop CRs, truncate to MAX_COLS, chunk by W.
  task automatic model(input byte unsigned s[$], output int exp_q[$],
                       output int rows, output logic err);
    byte unsigned line[$];
    int r = 0;
    err = 1'b0;
    exp_q.delete();
    for (int i = 0; i <= s.size(); i++) begin
      if (i == s.size() || s[i] == 8'h0A) begin
        if (line.size() > 0) begin
          int eff;
          eff = (line.size() > MAXC) ? MAXC : line.size();
          if (line.size() > MAXC) err = 1'b1;
          if (r < DEPTH) begin
            for (int c = 0; c < eff; c += W) begin
              int v = 0;
              for (int b = 0; b < W && c + b < eff; b++)
                if (line[c + b] == 8'h40) v |= (1 << b);
              exp_q.push_back((r << 8) | (c << 4) | v);
            end
          end else begin
            err = 1'b1;
          end
          r++;
        end
        line.delete();
      end else if (s[i] != 8'h0D) begin
        line.push_back(s[i]);
      end
    end
    rows = r;
  endtask

  task automatic feed_char(input byte unsigned ch, input bit last, output bit ok);
    int b = 0;
    char_in = ch;
    char_valid_in = 1'b1;
    char_last_in = last;
    while (!char_ready_out && b < 100) begin
      @(negedge clock);
      b++;
    end
    ok = char_ready_out;
    if (!ok) check("char_ready", char_ready_out, 1);
    @(negedge clock);
    char_valid_in = 1'b0;
    char_last_in = 1'($urandom_range(0, 1));
    char_in = 8'($urandom);
  endtask

  task automatic run_stream(input byte unsigned s[$], input int ad, input int bh,
                            input int exp_q[$], input int exp_rows, input logic exp_err);
    bit ok = 1'b1;
    int b = 0;
    ack_delay = ad;
    busy_hold = bh;
    got.delete();
    @(negedge clock);
    start_in = 1'b1;
    @(negedge clock);
    start_in = 1'b0;
    for (int i = 0; i < s.size() && ok; i++) begin
      feed_char(s[i], i == s.size() - 1, ok);
      repeat ($urandom_range(0, 1)) @(negedge clock);
    end
    char_last_in = 1'b0;
    while (!done_out && b < 200) begin
      @(negedge clock);
      b++;
    end
    check("done_out", done_out, 1);
    check("write_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("write[%0d] row/col/vec", i), got[i], exp_q[i]);
    if (exp_rows >= 0) check("rows_out", rows_out, exp_rows);
    check("overflow_err_out", overflow_err_out, exp_err);
    check("char_ready_in_done", char_ready_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    byte unsigned q[$];
    int exp_q[$];
    int rows;
    logic err;
    bit ok;

    vecs[0] = '{"@.@@.\n",            2, 0, 2, 72'h00D_040_000_000_000_000,  1, 1'b0};
    vecs[1] = '{"@@@@\n\n@",          1, 1, 2, 72'h00F_101_000_000_000_000,  2, 1'b0};
    vecs[2] = '{"@@@@@@@@@@@@\n",     1, 0, 3, 72'h00F_04F_083_000_000_000,  1, 1'b1};
    vecs[3] = '{"@\n@\n@\n@\n@\n",    3, 2, 4, 72'h001_101_201_301_000_000, -1, 1'b1};
    vecs[4] = '{".@\015\n.@.@@\015\n", 1, 0, 3, 72'h002_10A_141_000_000_000,  2, 1'b0};
    vecs[5] = '{"..\n..@.\n",         2, 1, 2, 72'h000_104_000_000_000_000,  2, 1'b0};
    vecs[6] = '{"\n\n\n",             1, 0, 0, 72'h000_000_000_000_000_000,  0, 1'b0};

    reset = 1'b1; start_in = 1'b0; char_valid_in = 1'b0;
    char_last_in = 1'b0; char_in = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_write_en", write_en_out, 0);
    check("rst_done", done_out, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_outputs", {write_en_out, row_addr_out, col_addr_out, partial_vec_out,
                           rows_out, overflow_err_out, done_out, char_ready_out}, 0);
    char_valid_in = 1'b1;
    char_in = 8'h40;
    repeat (3) begin
      @(negedge clock);
      check("idle_not_ready", char_ready_out, 0);
    end
    char_valid_in = 1'b0;
    check("idle_no_write", write_en_out, 0);

    foreach (vecs[k]) begin
      q.delete();
      exp_q.delete();
      for (int i = 0; i < vecs[k].txt.len(); i++) q.push_back(vecs[k].txt[i]);
      for (int i = 0; i < vecs[k].n_w; i++) exp_q.push_back(int'(vecs[k].ws[(5 - i) * 12 +: 12]));
      run_stream(q, vecs[k].ack_d, vecs[k].busy_h, exp_q, vecs[k].rows, vecs[k].err);
    end

    // Reset while a write is outstanding, then a clean reload from row 0.
    hold_ack = 1'b1;
    @(negedge clock);
    start_in = 1'b1;
    @(negedge clock);
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) feed_char(8'h40, 1'b0, ok);
    check("latency_write_en", write_en_out, 1);
    check("latency_write", cur_write(), 32'h00F);
    repeat (3) begin
      @(negedge clock);
      check("write_held_no_ack", write_en_out, 1);
    end
    reset = 1'b1;
    @(negedge clock);
    check("midwrite_rst_we", write_en_out, 0);
    check("midwrite_rst_idle", {char_ready_out, done_out, rows_out}, 0);
    reset = 1'b0;
    hold_ack = 1'b0;
    q = '{8'h2E, 8'h40, 8'h0A};
    exp_q = '{32'h002};
    run_stream(q, 1, 0, exp_q, 1, 1'b0);

    for (int it = 0; it < 25; it++) begin
      int nl;
      q.delete();
      nl = $urandom_range(1, 6);
      for (int l = 0; l < nl; l++) begin
        int len;
        len = $urandom_range(0, 12);
        for (int c = 0; c < len; c++) begin
          int r;
          r = $urandom_range(0, 9);
          q.push_back(r < 5 ? 8'h40 : (r < 9 ? 8'h2E : 8'h0D));
        end
        if (l < nl - 1 || $urandom_range(0, 1) == 1) q.push_back(8'h0A);
      end
      if (q.size() == 0) q.push_back(8'h40);
      model(q, exp_q, rows, err);
      run_stream(q, $urandom_range(1, 3), $urandom_range(0, 2), exp_q,
                 (rows <= DEPTH) ? rows : -1, err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
